// File: rtl/rf_wr_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Both the LU write FIFO and the write-port mux use wr_req_t.
package rf_wr_arbiter_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam int NREGS  = 32;

    typedef struct packed {
        logic [REG_W-1:0]  a3;
        logic [DATA_W-1:0] wd;
    } wr_req_t;

    // r0 is never tracked, so a query of r0 never reports busy
    function automatic logic reg_busy(input logic [NREGS-1:0] busy,
                                      input logic [REG_W-1:0] addr);
        return (addr != {REG_W{1'b0}}) && busy[addr];
    endfunction

endpackage

// File: rtl/rf_wr_fifo.sv
// Small in-order FIFO holding pending long-latency register writes.
// Pointers wrap modulo DEPTH; the occupancy count tells full from empty.
module rf_wr_fifo
    import rf_wr_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    i_clk,
    input  logic    i_rst,
    input  logic    i_push,
    input  wr_req_t i_din,
    input  logic    i_pop,
    output logic    o_full,
    output logic    o_empty,
    output wr_req_t o_head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    wr_req_t          r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == {CNT_W{1'b0}});
    assign o_head  = r_mem[r_rd_ptr];

    // Overflow/underflow requests are dropped rather than corrupting state
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // Entry storage; contents are don't-care while the slot is unoccupied
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter: WB has fixed priority, LU results queue in a FIFO.
// Also holds the long-latency busy scoreboard and the WB-starvation stall request.
module rf_wr_arbiter
    import rf_wr_arbiter_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_wr,
    input  logic [REG_W-1:0]  wb_a3,
    input  logic [DATA_W-1:0] wb_wd,
    input  logic              lu_valid,
    input  logic [REG_W-1:0]  lu_a3,
    input  logic [DATA_W-1:0] lu_wd,
    output logic              lu_ready,
    input  logic              issue_set,
    input  logic [REG_W-1:0]  issue_rd,
    input  logic [REG_W-1:0]  chk_a1,
    input  logic [REG_W-1:0]  chk_a2,
    input  logic [REG_W-1:0]  chk_a3,
    output logic              busy_hit,
    output logic              stall_req,
    output logic              sb_err,
    output logic              rf_wr,
    output logic [REG_W-1:0]  rf_a3,
    output logic [DATA_W-1:0] rf_wd
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);

    logic             w_wb_act;
    logic             w_full;
    logic             w_empty;
    wr_req_t          w_head;
    wr_req_t          w_lu_req;
    logic             w_push;
    logic             w_pop;
    logic             w_set;
    logic [NREGS-1:0] w_busy_next;
    logic [SC_W-1:0]  w_cnt_next;

    logic [NREGS-1:0] r_busy;
    logic             r_sb_err;
    logic [SC_W-1:0]  r_cnt;
    logic             r_stall;

    // WB writes to r0 are squashed so they never steal the port from the FIFO
    assign w_wb_act = wb_wr && (wb_a3 != {REG_W{1'b0}});
    assign lu_ready = !w_full && !rst;
    assign w_push   = lu_valid && lu_ready && (lu_a3 != {REG_W{1'b0}});
    assign w_pop    = !rst && !w_wb_act && !w_empty;
    assign w_set    = issue_set && (issue_rd != {REG_W{1'b0}});
    assign w_lu_req = '{a3: lu_a3, wd: lu_wd};

    rf_wr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_push),
        .i_din   (w_lu_req),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    // Write-port mux
    always_comb begin
        rf_wr = 1'b0;
        rf_a3 = {REG_W{1'b0}};
        rf_wd = {DATA_W{1'b0}};
        if (rst) begin
            rf_wr = 1'b0;
        end else if (w_wb_act) begin
            rf_wr = 1'b1;
            rf_a3 = wb_a3;
            rf_wd = wb_wd;
        end else if (!w_empty) begin
            rf_wr = 1'b1;
            rf_a3 = w_head.a3;
            rf_wd = w_head.wd;
        end else begin
            rf_wr = 1'b0;
        end
    end

    // Scoreboard next state: a same-cycle issue overrides the writeback clear
    always_comb begin
        w_busy_next = r_busy;
        if (w_pop) begin
            w_busy_next[w_head.a3] = 1'b0;
        end else begin
            w_busy_next = r_busy;
        end
        if (w_set) begin
            w_busy_next[issue_rd] = 1'b1;
        end else begin
            w_busy_next[0] = 1'b0;
        end
        w_busy_next[0] = 1'b0;
    end

    // Scoreboard and sticky double-issue error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy   <= {NREGS{1'b0}};
            r_sb_err <= 1'b0;
        end else begin
            r_busy <= w_busy_next;
            if (w_set && r_busy[issue_rd]) begin
                r_sb_err <= 1'b1;
            end else begin
                r_sb_err <= r_sb_err;
            end
        end
    end

    // Starvation counter next state; any pop means the FIFO is making progress
    always_comb begin
        w_cnt_next = r_cnt;
        if (w_pop) begin
            w_cnt_next = {SC_W{1'b0}};
        end else if (w_full && w_wb_act && (r_cnt != SC_W'(STARVE_MAX))) begin
            w_cnt_next = r_cnt + SC_W'(1);
        end else begin
            w_cnt_next = r_cnt;
        end
    end

    // Counter and registered stall flag tracking counter==STARVE_MAX
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= {SC_W{1'b0}};
            r_stall <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_next;
            r_stall <= (w_cnt_next == SC_W'(STARVE_MAX));
        end
    end

    assign stall_req = r_stall && !rst;
    assign sb_err    = r_sb_err;
    assign busy_hit  = reg_busy(r_busy, chk_a1) ||
                       reg_busy(r_busy, chk_a2) ||
                       reg_busy(r_busy, chk_a3);

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed bench for rf_wr_arbiter: expected port writes go into a cycle-stamped
// queue that a negedge monitor drains; status outputs are checked inline.
module tb_rf_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_wr;
    logic [4:0]  wb_a3;
    logic [31:0] wb_wd;
    logic        lu_valid;
    logic [4:0]  lu_a3;
    logic [31:0] lu_wd;
    logic        lu_ready;
    logic        issue_set;
    logic [4:0]  issue_rd;
    logic [4:0]  chk_a1;
    logic [4:0]  chk_a2;
    logic [4:0]  chk_a3;
    logic        busy_hit;
    logic        stall_req;
    logic        sb_err;
    logic        rf_wr;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;

    typedef struct {
        int          cyc;
        logic [4:0]  a3;
        logic [31:0] wd;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec   = 0;
    int   n_fail  = 0;
    int   cyc_cnt = 0;

    rf_wr_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .wb_wr     (wb_wr),
        .wb_a3     (wb_a3),
        .wb_wd     (wb_wd),
        .lu_valid  (lu_valid),
        .lu_a3     (lu_a3),
        .lu_wd     (lu_wd),
        .lu_ready  (lu_ready),
        .issue_set (issue_set),
        .issue_rd  (issue_rd),
        .chk_a1    (chk_a1),
        .chk_a2    (chk_a2),
        .chk_a3    (chk_a3),
        .busy_hit  (busy_hit),
        .stall_req (stall_req),
        .sb_err    (sb_err),
        .rf_wr     (rf_wr),
        .rf_a3     (rf_a3),
        .rf_wd     (rf_wd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, want finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    // Monitor: every port write must match the queue head for this very cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].cyc < cyc_cnt) begin
            n_vec++;
            n_fail++;
            $display("FAIL missed_write: got no write in cycle %0d, want a3=%0d wd=0x%0h",
                     exp_q[0].cyc, exp_q[0].a3, exp_q[0].wd);
            void'(exp_q.pop_front());
        end
        if (rf_wr === 1'b1) begin
            if (exp_q.size() == 0 || exp_q[0].cyc != cyc_cnt) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_write: got a3=%0d wd=0x%0h in cycle %0d, want no write",
                         rf_a3, rf_wd, cyc_cnt);
            end else begin
                mon_e = exp_q.pop_front();
                check("rf_a3", 32'(rf_a3), 32'(mon_e.a3));
                check("rf_wd", rf_wd, mon_e.wd);
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
        rst = 1'b0; wb_wr = 1'b0; wb_a3 = 5'd0; wb_wd = 32'd0;
        lu_valid = 1'b0; lu_a3 = 5'd0; lu_wd = 32'd0;
        issue_set = 1'b0; issue_rd = 5'd0;
        chk_a1 = 5'd0; chk_a2 = 5'd0; chk_a3 = 5'd0;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic expw(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back(exp_t'{cyc: cyc_cnt, a3: a, wd: d});
    endtask

    task automatic wbw(input logic [4:0] a, input logic [31:0] d);
        wb_wr = 1'b1; wb_a3 = a; wb_wd = d;
        if (a != 5'd0) expw(a, d);
    endtask

    task automatic lu(input logic [4:0] a, input logic [31:0] d);
        lu_valid = 1'b1; lu_a3 = a; lu_wd = d;
    endtask

    task automatic iss(input logic [4:0] rd);
        issue_set = 1'b1; issue_rd = rd;
    endtask

    initial begin
        rst = 1'b1; wb_wr = 1'b0; wb_a3 = 5'd0; wb_wd = 32'd0;
        lu_valid = 1'b0; lu_a3 = 5'd0; lu_wd = 32'd0;
        issue_set = 1'b0; issue_rd = 5'd0;
        chk_a1 = 5'd0; chk_a2 = 5'd0; chk_a3 = 5'd0;
        settle();
        check("rst_rf_wr", 32'(rf_wr), 32'd0);
        check("rst_lu_ready", 32'(lu_ready), 32'd0);
        check("rst_stall", 32'(stall_req), 32'd0);
        nxt(); rst = 1'b1; wb_wr = 1'b1; wb_a3 = 5'd4; wb_wd = 32'h44;
        settle();
        check("rst_wb_gated", 32'(rf_wr), 32'd0);
        nxt(); settle();
        check("post_rst_ready", 32'(lu_ready), 32'd1);
        check("post_rst_sb_err", 32'(sb_err), 32'd0);
        check("post_rst_stall", 32'(stall_req), 32'd0);

        // Basic LU write and scoreboard set/clear on r5
        nxt(); iss(5'd5); chk_a1 = 5'd5; settle();
        check("busy5_same_cycle", 32'(busy_hit), 32'd0);
        nxt(); lu(5'd5, 32'h1234); chk_a1 = 5'd5; settle();
        check("lu_ready_empty", 32'(lu_ready), 32'd1);
        check("busy5_set", 32'(busy_hit), 32'd1);
        nxt(); expw(5'd5, 32'h1234); chk_a1 = 5'd5; settle();
        check("busy5_during_pop", 32'(busy_hit), 32'd1);
        nxt(); chk_a1 = 5'd5; settle();
        check("busy5_cleared", 32'(busy_hit), 32'd0);

        // WB priority over a pending FIFO entry, then r0 WB lets it drain
        nxt(); lu(5'd7, 32'h77); iss(5'd7); settle();
        nxt(); wbw(5'd3, 32'hAAAA); chk_a2 = 5'd7; settle();
        check("busy7_pending", 32'(busy_hit), 32'd1);
        nxt(); wb_wr = 1'b1; wb_a3 = 5'd0; wb_wd = 32'hBBBB; expw(5'd7, 32'h77); settle();
        nxt(); chk_a3 = 5'd7; settle();
        check("busy7_cleared", 32'(busy_hit), 32'd0);

        // Fill the FIFO under constant WB traffic and starve it
        nxt(); wbw(5'd1, 32'h101); lu(5'd10, 32'hA0); iss(5'd10); settle();
        check("ready_fill0", 32'(lu_ready), 32'd1);
        nxt(); wbw(5'd1, 32'h102); lu(5'd11, 32'hB0); iss(5'd11); settle();
        check("ready_fill1", 32'(lu_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            nxt(); wbw(5'd1, 32'h110 + 32'(i)); settle();
            check("ready_full", 32'(lu_ready), 32'd0);
            check("stall_early", 32'(stall_req), 32'd0);
        end
        nxt(); wbw(5'd1, 32'h120); lu(5'd12, 32'hC0); settle();
        check("stall_set", 32'(stall_req), 32'd1);
        check("ready_full_sat", 32'(lu_ready), 32'd0);
        nxt(); expw(5'd10, 32'hA0); chk_a1 = 5'd10; settle();
        check("stall_hold_at_pop", 32'(stall_req), 32'd1);
        check("busy10_at_pop", 32'(busy_hit), 32'd1);
        nxt(); expw(5'd11, 32'hB0); chk_a1 = 5'd10; settle();
        check("stall_fall", 32'(stall_req), 32'd0);
        check("ready_after_pop", 32'(lu_ready), 32'd1);
        check("busy10_cleared", 32'(busy_hit), 32'd0);
        nxt(); chk_a2 = 5'd11; settle();
        check("busy11_cleared", 32'(busy_hit), 32'd0);

        // Double issue error, then issue racing a pop of the same register
        nxt(); iss(5'd9); settle();
        check("sb_err_first", 32'(sb_err), 32'd0);
        nxt(); iss(5'd9); lu(5'd9, 32'h99); settle();
        check("sb_err_pre", 32'(sb_err), 32'd0);
        nxt(); iss(5'd9); expw(5'd9, 32'h99); chk_a1 = 5'd9; settle();
        check("sb_err_set", 32'(sb_err), 32'd1);
        check("busy9_set", 32'(busy_hit), 32'd1);
        nxt(); chk_a1 = 5'd9; settle();
        check("busy9_set_wins", 32'(busy_hit), 32'd1);
        check("sb_err_sticky", 32'(sb_err), 32'd1);

        // r0 handling on both requesters
        nxt(); lu(5'd0, 32'hDEAD); chk_a1 = 5'd9; settle();
        check("ready_r0", 32'(lu_ready), 32'd1);
        nxt(); chk_a1 = 5'd9; settle();
        check("r0_no_write", 32'(rf_wr), 32'd0);
        check("busy9_unchanged", 32'(busy_hit), 32'd1);
        nxt(); wb_wr = 1'b1; wb_a3 = 5'd0; wb_wd = 32'hFFFF; settle();
        check("wb_r0_squash", 32'(rf_wr), 32'd0);

        // Reset with a full FIFO and busy bits outstanding
        nxt(); lu(5'd20, 32'h200); iss(5'd20); settle();
        nxt(); lu(5'd21, 32'h210); iss(5'd21); wbw(5'd2, 32'h222); settle();
        nxt(); wbw(5'd2, 32'h223); chk_a1 = 5'd20; settle();
        check("ready_full2", 32'(lu_ready), 32'd0);
        check("busy20_set", 32'(busy_hit), 32'd1);
        nxt(); rst = 1'b1; wb_wr = 1'b1; wb_a3 = 5'd2; wb_wd = 32'h224; settle();
        check("midrst_rf_wr", 32'(rf_wr), 32'd0);
        check("midrst_ready", 32'(lu_ready), 32'd0);
        nxt(); chk_a1 = 5'd20; chk_a2 = 5'd21; chk_a3 = 5'd9; settle();
        check("midrst_busy", 32'(busy_hit), 32'd0);
        check("midrst_sb_err", 32'(sb_err), 32'd0);
        check("midrst_stall", 32'(stall_req), 32'd0);
        check("midrst_ready_after", 32'(lu_ready), 32'd1);
        check("midrst_fifo_empty", 32'(rf_wr), 32'd0);
        nxt(); nxt(); settle();
        check("exp_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_wr_arbiter.md
Name: rf_wr_arbiter

Overview:
- Arbitrates the single register-file write port (rf_wr/rf_a3/rf_wd) between two requesters:
  - the pipeline WB stage, which has fixed priority and no backpressure;
  - the long-latency unit (mult/div), through a valid/ready handshake and a DEPTH-entry FIFO.
- Keeps a busy scoreboard of registers with long-latency writes in flight, for the hazard unit.
- Raises stall_req when WB traffic starves the LU FIFO.

Parameters:
- DEPTH, 2: LU write FIFO entries; power of two, minimum 2.
- STARVE_MAX, 4: consecutive cycles with FIFO full and drain blocked before stall_req asserts.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- wb_wr  in  1  WB stage write request.
- wb_a3  in  5  WB destination register.
- wb_wd  in  32  WB write data.
- lu_valid  in  1  LU result valid.
- lu_a3  in  5  LU destination register.
- lu_wd  in  32  LU result data.
- lu_ready  out  1  FIFO can accept an entry.
- issue_set  in  1  a long-latency op issues this cycle.
- issue_rd  in  5  destination register of the issued op.
- chk_a1, chk_a2, chk_a3  in  5 each  registers queried by the hazard unit.
- busy_hit  out  1  any nonzero chk_* register is marked busy.
- stall_req  out  1  freeze the pipeline so WB bubbles.
- sb_err  out  1  sticky: issue targeted an already-busy register.
- rf_wr  out  1  register-file write enable.
- rf_a3  out  5  register-file write address.
- rf_wd  out  32  register-file write data.

Behaviour:
- Reset (rst=1 at posedge):
  - FIFO emptied, scoreboard cleared, starvation counter cleared to 0, sb_err=0.
  - While rst=1: lu_ready=0, stall_req=0, rf_wr=0, rf_a3=0, rf_wd=0.
  - An entry accepted before reset is lost; the scoreboard clear makes that consistent.
- Write-port mux (combinational, zero latency):
  - wb_act = wb_wr && wb_a3!=0. When wb_act: rf_wr=1, rf_a3=wb_a3, rf_wd=wb_wd.
  - Otherwise, when the FIFO is non-empty: rf_wr=1 and rf_a3/rf_wd come from the FIFO head; the head pops at this posedge.
  - Otherwise rf_wr=0, rf_a3=0, rf_wd=0.
  - WB writes to r0 are squashed and count as idle, so the FIFO drains in that cycle.
- LU handshake:
  - Enqueue when lu_valid && lu_ready at posedge.
  - lu_ready = !full && !rst. Simultaneous pop and push while full is not allowed (ready is low).
  - No bypass: an accepted entry reaches the port one cycle later at the earliest.
  - Entries with lu_a3==0 are accepted and discarded. They are not enqueued and do not touch the scoreboard.
  - FIFO order is preserved; pointers wrap modulo DEPTH; an occupancy count distinguishes full from empty.
- Scoreboard (busy[31:1]; busy[0] is always 0):
  - Set: issue_set && issue_rd!=0 sets busy[issue_rd] at posedge. If that bit is already 1, sb_err is set and stays 1 until reset.
  - Clear: a FIFO pop clears busy[popped a3].
  - Set and clear of the same register in one cycle: set wins.
  - busy_hit = OR over chk_a1, chk_a2, chk_a3 of (addr!=0 && busy[addr]). Combinational from current state; same-cycle sets and clears are not visible until the next cycle.
- Starvation:
  - Counter increments each cycle that the FIFO is full and wb_act=1; saturates at STARVE_MAX.
  - Counter clears on any cycle with a pop.
  - stall_req is registered: 1 while counter==STARVE_MAX.
  - The pipeline responds to stall_req with wb_wr=0, the FIFO drains, and stall_req falls the cycle after the pop.

Decomposition:
- Shared package:
  - REG_W=5, DATA_W=32, NREGS=32.
  - A wr_req struct {a3, wd} used by both the FIFO and the mux.
- One sub-module: rf_wr_fifo (parameterised DEPTH, push/pop/full/empty/head).
- Scoreboard, mux and starvation counter stay in the top level.

Test Plan:
- Write-port mux and scoreboard basics:
  - Reset, then issue_set rd=5, then lu_valid a3=5 wd=0x1234 with wb_wr=0 -> lu_ready=1. Next cycle rf_wr=1, rf_a3=5, rf_wd=0x1234; busy[5] clears after that posedge; busy_hit with chk_a1=5 goes 1 then 0.
  - wb_wr=1 a3=3 wd=0xAAAA with one FIFO entry a3=7 pending -> port shows a3=3. The FIFO entry writes the next cycle wb_wr=0 or wb_a3=0.
- FIFO fill and drain:
  - Hold wb_wr=1 a3=1 while pushing 2 LU entries -> lu_ready=0 after the 2nd.
  - Continuing WB writes -> stall_req=1 after 4 full cycles.
  - Then wb_wr=0 -> entries pop in order; stall_req falls the cycle after the first pop.
- Scoreboard edge cases:
  - issue_set rd=9 twice without writeback -> sb_err=1, held until rst.
  - issue_set rd=9 in the same cycle as a pop of a3=9 -> busy[9] remains 1.
- r0 handling:
  - lu_valid a3=0 -> accepted, no rf_wr, scoreboard unchanged.
  - wb_wr=1 a3=0 -> rf_wr=0, or a FIFO drain if the FIFO is non-empty.
- Reset mid-operation:
  - rst=1 with FIFO full and busy bits set -> next cycle the FIFO is empty, busy_hit=0, stall_req=0, sb_err=0.
  - After rst falls -> lu_ready=1.
